// File: rtl/display_grant_arbiter_if.sv
// Request/grant bundle between the two display requesters (IE01, IE02) and the
// seven-segment display arbiter.
interface display_grant_arbiter_if;
    logic req1;
    logic req2;
    logic priorsel;
    logic gnt1;
    logic gnt2;
    logic displaysel;
    logic busy;
    logic preempt;

    modport master (
        output req1,
        output req2,
        output priorsel,
        input  gnt1,
        input  gnt2,
        input  displaysel,
        input  busy,
        input  preempt
    );

    modport slave (
        input  req1,
        input  req2,
        input  priorsel,
        output gnt1,
        output gnt2,
        output displaysel,
        output busy,
        output preempt
    );
endinterface

// File: rtl/display_grant_arbiter.sv
// Grants the seven-segment display to IE01 or IE02 with minimum/maximum hold
// times and a one-cycle blank between owners. All outputs are registered.
module display_grant_arbiter #(
    parameter int unsigned MINHOLD = 4,
    parameter int unsigned MAXHOLD = 16,
    parameter int unsigned CNTW    = 8
) (
    input logic                     clk,
    input logic                     rst,
    display_grant_arbiter_if.slave  arb
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT1 = 2'd1;
    localparam logic [1:0] GNT2 = 2'd2;
    localparam logic [1:0] GAP  = 2'd3;

    localparam logic OWNER_IE01 = 1'b0;
    localparam logic OWNER_IE02 = 1'b1;

    localparam logic [CNTW-1:0] MIN_C = CNTW'(MINHOLD);
    localparam logic [CNTW-1:0] MAX_C = CNTW'(MAXHOLD);
    localparam logic [CNTW-1:0] ONE_C = CNTW'(1);

    logic [1:0]      state_q,   state_d;
    logic [CNTW-1:0] cnt_q,     cnt_d;
    logic            gnt1_q,    gnt1_d;
    logic            gnt2_q,    gnt2_d;
    logic            dsel_q,    dsel_d;
    logic            busy_q,    busy_d;
    logic            preempt_q, preempt_d;
    logic            last_q,    last_d;

    logic take1;
    logic take2;
    logic own_req;
    logic opp_req;
    logic norm_rel;
    logic pre_rel;

    always_comb begin
        // NOTE: every combinational output gets a default first so that no path
        // through the case leaves it unassigned and infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        gnt1_d    = gnt1_q;
        gnt2_d    = gnt2_q;
        dsel_d    = dsel_q;
        last_d    = last_q;
        preempt_d = 1'b0;
        take1     = 1'b0;
        take2     = 1'b0;
        own_req   = (state_q == GNT2) ? arb.req2 : arb.req1;
        opp_req   = (state_q == GNT2) ? arb.req1 : arb.req2;
        norm_rel  = !own_req && (cnt_q >= MIN_C);
        pre_rel   = opp_req && (cnt_q >= MAX_C);

        case (state_q)
            IDLE: begin
                if (arb.req1 && (!arb.req2 || !arb.priorsel)) begin
                    take1 = 1'b1;
                end else if (arb.req2) begin
                    take2 = 1'b1;
                end
            end

            GNT1, GNT2: begin
                if (norm_rel || pre_rel) begin
                    state_d   = GAP;
                    cnt_d     = '0;
                    gnt1_d    = 1'b0;
                    gnt2_d    = 1'b0;
                    last_d    = (state_q == GNT2) ? OWNER_IE02 : OWNER_IE01;
                    // A simultaneous normal release masks the preemption flag.
                    preempt_d = pre_rel && !norm_rel;
                end else if (cnt_q != MAX_C) begin
                    cnt_d = cnt_q + ONE_C;
                end
            end

            default: begin
                // GAP: round robin when both wait; priorsel plays no part here.
                if (arb.req1 && arb.req2) begin
                    take1 = (last_q == OWNER_IE02);
                    take2 = (last_q == OWNER_IE01);
                end else if (arb.req1) begin
                    take1 = 1'b1;
                end else if (arb.req2) begin
                    take2 = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase

        if (take1) begin
            state_d = GNT1;
            cnt_d   = ONE_C;
            gnt1_d  = 1'b1;
            gnt2_d  = 1'b0;
            dsel_d  = 1'b0;
        end else if (take2) begin
            state_d = GNT2;
            cnt_d   = ONE_C;
            gnt1_d  = 1'b0;
            gnt2_d  = 1'b1;
            dsel_d  = 1'b1;
        end

        busy_d = gnt1_d | gnt2_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            gnt1_q    <= 1'b0;
            gnt2_q    <= 1'b0;
            dsel_q    <= 1'b0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
            last_q    <= OWNER_IE01;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gnt1_q    <= gnt1_d;
            gnt2_q    <= gnt2_d;
            dsel_q    <= dsel_d;
            busy_q    <= busy_d;
            preempt_q <= preempt_d;
            last_q    <= last_d;
        end
    end

    assign arb.gnt1       = gnt1_q;
    assign arb.gnt2       = gnt2_q;
    assign arb.displaysel = dsel_q;
    assign arb.busy       = busy_q;
    assign arb.preempt    = preempt_q;

endmodule

// File: tb/tb_display_grant_arbiter.sv
// Directed bench for display_grant_arbiter; observed vector is
// {gnt1, gnt2, displaysel, busy, preempt}.
module tb_display_grant_arbiter;

    localparam logic [4:0] E_IDLE0 = 5'b00000;
    localparam logic [4:0] E_IDLE1 = 5'b00100;
    localparam logic [4:0] E_G1    = 5'b10010;
    localparam logic [4:0] E_G2    = 5'b01110;
    localparam logic [4:0] E_PRE0  = 5'b00001;
    localparam logic [4:0] E_PRE1  = 5'b00101;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    display_grant_arbiter_if arb ();

    display_grant_arbiter #(
        .MINHOLD (4),
        .MAXHOLD (16),
        .CNTW    (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .arb (arb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [4:0] expv);
        logic [4:0] o;
        o = {arb.gnt1, arb.gnt2, arb.displaysel, arb.busy, arb.preempt};
        n_vec++;
        assert (o === expv) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, o, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input logic [4:0] expv, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            check(tag, expv);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        arb.req1     = 1'b0;
        arb.req2     = 1'b0;
        arb.priorsel = 1'b0;
        #12;
        check("reset", E_IDLE0);
        rst = 1'b0;
        tick();
        check("idle_no_req", E_IDLE0);

        // Single requester, then release through GAP to IDLE
        arb.req1 = 1'b1;
        run(10, E_G1, "t1_gnt1");
        arb.req1 = 1'b0;
        tick(); check("t1_gap", E_IDLE0);
        tick(); check("t1_idle", E_IDLE0);

        // Only the last owner requests during GAP
        arb.req1 = 1'b1;
        tick(); check("t1b_gnt1", E_G1);
        arb.req1 = 1'b0;
        run(3, E_G1, "t1b_minhold");
        tick(); check("t1b_gap", E_IDLE0);
        arb.req1 = 1'b1;
        tick(); check("t1b_gap_last_owner", E_G1);
        arb.req1 = 1'b0;
        run(3, E_G1, "t1b_minhold2");
        tick(); check("t1b_gap2", E_IDLE0);
        tick(); check("t1b_idle", E_IDLE0);

        // Simultaneous request from IDLE, priorsel decides
        arb.req1 = 1'b1; arb.req2 = 1'b1; arb.priorsel = 1'b1;
        tick(); check("t2_prio1", E_G2);
        arb.req1 = 1'b0; arb.req2 = 1'b0;
        run(3, E_G2, "t2_hold2");
        tick(); check("t2_gap", E_IDLE1);
        tick(); check("t2_idle", E_IDLE1);
        arb.req1 = 1'b1; arb.req2 = 1'b1; arb.priorsel = 1'b0;
        tick(); check("t2_prio0", E_G1);
        arb.req1 = 1'b0; arb.req2 = 1'b0;
        run(3, E_G1, "t2_hold1");
        tick(); check("t2_gap_b", E_IDLE0);
        tick(); check("t2_idle_b", E_IDLE0);

        // One-cycle req2 pulse holds the grant for MINHOLD cycles
        arb.req2 = 1'b1;
        tick(); check("t3_gnt2", E_G2);
        arb.req2 = 1'b0;
        run(3, E_G2, "t3_minhold");
        tick(); check("t3_gap", E_IDLE1);
        tick(); check("t3_idle", E_IDLE1);
        tick(); check("t3_idle2", E_IDLE1);

        // Preemption after MAXHOLD cycles
        arb.req1 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("t4_gnt1", E_G1);
            if (i == 2) arb.req2 = 1'b1;
        end
        tick(); check("t4_preempt", E_PRE0);
        tick(); check("t4_gnt2", E_G2);
        arb.req1 = 1'b0; arb.req2 = 1'b0;
        run(3, E_G2, "t4_hold2");
        tick(); check("t4_gap", E_IDLE1);
        tick(); check("t4_idle", E_IDLE1);

        // Round robin with both held; priorsel flipped after the first grant
        arb.req1 = 1'b1; arb.req2 = 1'b1; arb.priorsel = 1'b0;
        tick(); check("t5_first", E_G1);
        arb.priorsel = 1'b1;
        run(15, E_G1, "t5_gnt1_a");
        tick(); check("t5_gap_a", E_PRE0);
        run(16, E_G2, "t5_gnt2");
        tick(); check("t5_gap_b", E_PRE1);
        run(16, E_G1, "t5_gnt1_b");
        tick(); check("t5_gap_c", E_PRE0);
        run(3, E_G2, "t5_gnt2_b");

        // Asynchronous reset between edges mid-GNT2
        #2;
        rst = 1'b1;
        #1;
        check("t6_async", E_IDLE0);
        tick(); check("t6_held", E_IDLE0);
        arb.priorsel = 1'b0;
        #3;
        rst = 1'b0;
        tick(); check("t6_after", E_G1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
